bus_mem_responder: RTL and testbench
====================================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 The parameter DEPTH_WORDS SHALL default to 64; it is the number of 32-bit words in the backing store and must be a power of two.
REQ-002 The parameter WAIT_CYCLES SHALL default to 2; it is the number of wait states inserted before a response, with legal range 0..15.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port req SHALL be an input, 1 bit wide: initiator requests a transfer.
REQ-006 Port we SHALL be an input, 1 bit wide: 1 means write, 0 means read; valid while req is high.
REQ-007 Port addr SHALL be an input, 32 bits wide: byte address, word-aligned.
REQ-008 Port wdata SHALL be an input, 32 bits wide: write data.
REQ-009 Port rdata SHALL be an output, 32 bits wide: read data, valid while ready is high and err is low on a read.
REQ-010 Port ready SHALL be an output, 1 bit wide: one-cycle completion strobe.
REQ-011 Port err SHALL be an output, 1 bit wide: error qualifier, meaningful only while ready is high.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-013 In IDLE with req=1 at a rising edge, the block SHALL latch we, addr and wdata, clear the wait counter, and go to WAIT; if WAIT_CYCLES=0 it SHALL go straight to RESP.
REQ-014 In WAIT the counter SHALL increment each cycle; on the edge where counter = WAIT_CYCLES-1 the block SHALL go to RESP.
REQ-015 Latency: for a req first high in cycle 0, ready SHALL be high in exactly cycle 1+WAIT_CYCLES and SHALL be low in every other cycle of the transfer.
REQ-016 RESP SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-017 A req still high in the cycle after RESP SHALL be accepted as a new transfer, giving back-to-back operation with 1 idle cycle minimum.
REQ-018 The initiator holds req, we, addr and wdata stable until ready; changes to these inputs in WAIT or RESP SHALL be ignored, because the latched copies are used.
REQ-019 A request SHALL be an error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-020 For an error request: no memory access SHALL occur, err=1 together with ready, and rdata SHALL be unchanged.
REQ-021 A valid write SHALL update word addr[31:2] on the rising edge that enters RESP.
REQ-022 A valid read SHALL load rdata on the edge entering RESP; rdata SHALL hold that value until the next valid read completes.
REQ-023 A read that immediately follows a write to the same word SHALL return the newly written data.
REQ-024 err SHALL be 0 whenever ready is 0.

Reset
REQ-025 Asserting reset low at any time SHALL asynchronously force: state IDLE, ready=0, err=0, rdata=0, wait counter=0, latched request cleared.
REQ-026 A reset during WAIT SHALL abandon the transfer, and the pending write SHALL NOT be committed.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 The first request SHALL be accepted no earlier than the first rising edge after reset deasserts.

Structure
REQ-029 A shared package bus_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the 32-bit data and address width constants, and the wait-counter width.
REQ-030 The storage SHALL be a sub-module bus_ram: single-port, synchronous write, registered read, with no reset on its array.
REQ-031 The FSM, address check and output registers SHALL reside in bus_mem_responder.

Verification
REQ-032 Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10, then read 0x10 -> ready in cycle 3 of each transfer, read rdata=0xDEADBEEF, err=0.
REQ-033 WAIT_CYCLES=0: read with req held high continuously -> ready every 2nd cycle, and rdata matches prior writes.
REQ-034 Misaligned read of addr 0x0000_0006 -> ready=1 and err=1 in the same cycle, and rdata keeps its previous value.
REQ-035 Out-of-range write to addr 0x100 with DEPTH_WORDS=64 -> err=1, and a subsequent read of word 0 is unchanged.
REQ-036 Reset pulse low during the WAIT of a write of 0x12345678 to 0x4 -> ready never pulses, and a later read of 0x4 returns its old value.
REQ-037 Inputs changed mid-WAIT (addr 0x8 -> 0xC) -> the transfer completes using 0x8.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and widths for the bus memory responder and its backing store.
package bus_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/bus_ram.sv
// Single-port word store: synchronous write, registered read, one access per enabled cycle.
module bus_ram
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: no reset on the array or its read register; a reset would stop RAM inference.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Wait-state bus slave: latches a request, inserts WAIT_CYCLES wait states, then answers for one cycle.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

    state_t state, next_state;

    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_hold;
    logic [DATA_W-1:0] ram_rdata;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_err;
    logic              ready_d;
    logic              err_d;
    logic              ram_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state defaults to state first, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == LAST_CNT) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // In IDLE the live inputs drive the store so a zero-wait transfer can access it on the accepting edge.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
        end
        cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[ADDR_W-1:2] >= DEPTH_LIM);
        ready_d = (next_state == RESP);
        err_d   = ready_d && cur_err;
        ram_en  = ready_d && !cur_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready      <= 1'b0;
            err        <= 1'b0;
            rdata_hold <= '0;
        end else begin
            ready <= ready_d;
            err   <= err_d;
            if (state == IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (ready && !err && !we_q) begin
                rdata_hold <= ram_rdata;
            end
        end
    end

    // The store's read register is live only in the RESP cycle of a good read; otherwise show the held copy.
    assign rdata = (ready && !err && !we_q) ? ram_rdata : rdata_hold;

    bus_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (cur_we),
        .addr (cur_addr[AW+1:2]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized bench for bus_mem_responder with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances against a word-level model.
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req2, req0, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, err2, err0;

    always #5 clk = ~clk;

    bus_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .err(err2)
    );

    bus_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .err(err0)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem_m [2][64];
    logic [31:0] rd_m  [2];
    bit          at_resp  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd64);
    endfunction

    function automatic logic [31:0] rand_addr();
        int          p = $urandom_range(0, 9);
        logic [31:0] a = 32'($urandom_range(0, 63)) << 2;
        if (p == 0) a = a | 32'($urandom_range(1, 3));
        else if (p == 1) a = 32'($urandom_range(64, 4096)) << 2;
        return a;
    endfunction

    task automatic sample(input int sel, output logic r, output logic e, output logic [31:0] q);
        if (sel == 0) begin
            r = ready2; e = err2; q = rdata2;
        end else begin
            r = ready0; e = err0; q = rdata0;
        end
    endtask

    // sel 0 drives the 2-wait instance, sel 1 the 0-wait instance.
    task automatic xfer(input int sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, input bit scramble);
        int          wc  = (sel == 0) ? 2 : 0;
        bit          bad = is_bad(a);
        logic        r, e;
        logic [31:0] q;
        if (sel == 0) req2 = 1'b1; else req0 = 1'b1;
        we = w; addr = a; wdata = d;
        if (at_resp) @(negedge clk);
        sample(sel, r, e, q);
        check("c0_ready", r, 0);
        check("c0_rdata", q, rd_m[sel]);
        for (int k = 1; k <= wc; k++) begin
            @(negedge clk);
            sample(sel, r, e, q);
            check("wait_ready", r, 0);
            check("wait_err", e, 0);
            check("wait_rdata", q, rd_m[sel]);
            if (scramble) begin
                we = ~w; addr = a ^ 32'h4; wdata = ~d;
            end
        end
        @(negedge clk);
        sample(sel, r, e, q);
        if (!bad && w)  mem_m[sel][a[7:2]] = d;
        if (!bad && !w) rd_m[sel] = mem_m[sel][a[7:2]];
        check("resp_ready", r, 1);
        check("resp_err", e, 32'(bad));
        check("resp_rdata", q, rd_m[sel]);
        if (!keep) begin
            req2 = 1'b0; req0 = 1'b0;
        end
        at_resp = 1'b1;
    endtask

    task automatic idle(input int n);
        req2 = 1'b0; req0 = 1'b0;
        repeat (n) @(negedge clk);
        if (n > 0) at_resp = 1'b0;
    endtask

    task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] d);
        int pulses = 0;
        req2 = 1'b1; we = 1'b1; addr = a; wdata = d;
        if (at_resp) @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #2;
        check("rst_ready", ready2, 0);
        check("rst_err", err2, 0);
        check("rst_rdata2", rdata2, 0);
        check("rst_rdata0", rdata0, 0);
        req2 = 1'b0;
        #1 reset = 1'b1;
        rd_m[0] = '0; rd_m[1] = '0;
        repeat (8) begin
            @(negedge clk);
            if (ready2) pulses++;
        end
        check("rst_no_ready", pulses, 0);
        at_resp = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req2 = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        rd_m[0] = '0; rd_m[1] = '0;
        #23;
        check("reset_ready2", ready2, 0);
        check("reset_err2", err2, 0);
        check("reset_rdata2", rdata2, 0);
        check("reset_ready0", ready0, 0);
        check("reset_rdata0", rdata0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) xfer(0, 1'b1, 32'(i * 4), $urandom, 1'($urandom_range(0, 1)), 1'b0);

        // write then immediate read of the same word
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        idle(1);
        xfer(0, 1'b0, 32'h6, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b1, 32'h100, 32'hCAFEF00D, 1'b1, 1'b0);
        xfer(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // inputs disturbed mid-WAIT: 0x8 -> 0xC
        xfer(0, 1'b1, 32'h8, 32'h0BADF00D, 1'b0, 1'b1);
        xfer(0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0);
        xfer(0, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0);
        idle(2);
        reset_mid_wait(32'h4, 32'h12345678);
        xfer(0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            xfer(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        for (int i = 0; i < 64; i++) xfer(1, 1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0);
        // continuous req on the zero-wait instance: ready every second cycle
        for (int i = 0; i < 32; i++) xfer(1, 1'b0, 32'($urandom_range(0, 63)) << 2, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) begin
            xfer(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
